// File: rtl/ins_encoder_pkg.sv
// Shared MIPS opcode/function constants, the instruction-kind enum and a
// reference encode function usable by both the RTL and benches.
package ins_encoder_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FUNC_SLL  = 6'h00;
  localparam logic [5:0] FUNC_SRL  = 6'h02;
  localparam logic [5:0] FUNC_SRA  = 6'h03;
  localparam logic [5:0] FUNC_SLLV = 6'h04;
  localparam logic [5:0] FUNC_SRLV = 6'h06;
  localparam logic [5:0] FUNC_SRAV = 6'h07;
  localparam logic [5:0] FUNC_JR   = 6'h08;
  localparam logic [5:0] FUNC_ADD  = 6'h20;
  localparam logic [5:0] FUNC_ADDU = 6'h21;
  localparam logic [5:0] FUNC_SUB  = 6'h22;
  localparam logic [5:0] FUNC_SUBU = 6'h23;
  localparam logic [5:0] FUNC_AND  = 6'h24;
  localparam logic [5:0] FUNC_OR   = 6'h25;
  localparam logic [5:0] FUNC_XOR  = 6'h26;
  localparam logic [5:0] FUNC_NOR  = 6'h27;
  localparam logic [5:0] FUNC_SLT  = 6'h2A;
  localparam logic [5:0] FUNC_SLTU = 6'h2B;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [4:0] {
    INS_NOP,
    INS_ADD, INS_ADDU, INS_SUB, INS_SUBU, INS_AND, INS_OR, INS_XOR, INS_NOR,
    INS_SLT, INS_SLTU,
    INS_SLL, INS_SRL, INS_SRA,
    INS_SLLV, INS_SRLV, INS_SRAV,
    INS_JR,
    INS_ADDI, INS_ADDIU, INS_ORI, INS_XORI, INS_LW, INS_SW, INS_BEQ, INS_BNE,
    INS_SLTI, INS_SLTIU,
    INS_LUI,
    INS_J, INS_JAL
  } ins_t;

  // Highest defined kind; anything above it is an illegal encoding request.
  localparam logic [4:0] INS_LAST = 5'(INS_JAL);

  function automatic logic kind_is_legal(input ins_t kind);
    return 5'(kind) <= INS_LAST;
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] shamt,
                                        input logic [5:0] func);
    return {OP_RTYPE, rs, rt, rd, shamt, func};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Pack a mnemonic-level request into a MIPS word; unused fields are zeroed
  // and unknown kinds fall back to NOP.
  function automatic logic [31:0] encode(input ins_t kind, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] shamt, input logic [15:0] imm,
                                         input logic [25:0] target);
    logic [31:0] w;
    w = NOP_WORD;
    case (kind)
      INS_ADD:   w = rtype(rs, rt, rd, 5'd0, FUNC_ADD);
      INS_ADDU:  w = rtype(rs, rt, rd, 5'd0, FUNC_ADDU);
      INS_SUB:   w = rtype(rs, rt, rd, 5'd0, FUNC_SUB);
      INS_SUBU:  w = rtype(rs, rt, rd, 5'd0, FUNC_SUBU);
      INS_AND:   w = rtype(rs, rt, rd, 5'd0, FUNC_AND);
      INS_OR:    w = rtype(rs, rt, rd, 5'd0, FUNC_OR);
      INS_XOR:   w = rtype(rs, rt, rd, 5'd0, FUNC_XOR);
      INS_NOR:   w = rtype(rs, rt, rd, 5'd0, FUNC_NOR);
      INS_SLT:   w = rtype(rs, rt, rd, 5'd0, FUNC_SLT);
      INS_SLTU:  w = rtype(rs, rt, rd, 5'd0, FUNC_SLTU);
      INS_SLL:   w = rtype(5'd0, rt, rd, shamt, FUNC_SLL);
      INS_SRL:   w = rtype(5'd0, rt, rd, shamt, FUNC_SRL);
      INS_SRA:   w = rtype(5'd0, rt, rd, shamt, FUNC_SRA);
      INS_SLLV:  w = rtype(rs, rt, rd, 5'd0, FUNC_SLLV);
      INS_SRLV:  w = rtype(rs, rt, rd, 5'd0, FUNC_SRLV);
      INS_SRAV:  w = rtype(rs, rt, rd, 5'd0, FUNC_SRAV);
      INS_JR:    w = rtype(rs, 5'd0, 5'd0, 5'd0, FUNC_JR);
      INS_ADDI:  w = itype(OP_ADDI, rs, rt, imm);
      INS_ADDIU: w = itype(OP_ADDIU, rs, rt, imm);
      INS_ORI:   w = itype(OP_ORI, rs, rt, imm);
      INS_XORI:  w = itype(OP_XORI, rs, rt, imm);
      INS_LW:    w = itype(OP_LW, rs, rt, imm);
      INS_SW:    w = itype(OP_SW, rs, rt, imm);
      INS_BEQ:   w = itype(OP_BEQ, rs, rt, imm);
      INS_BNE:   w = itype(OP_BNE, rs, rt, imm);
      INS_SLTI:  w = itype(OP_SLTI, rs, rt, imm);
      INS_SLTIU: w = itype(OP_SLTIU, rs, rt, imm);
      INS_LUI:   w = itype(OP_LUI, 5'd0, rt, imm);
      INS_J:     w = {OP_J, target};
      INS_JAL:   w = {OP_JAL, target};
      default:   w = NOP_WORD;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ins_encoder_fifo.sv
// Synchronous first-word-fall-through FIFO for encoded words. Flush has
// priority over push and pop; the head word reads as zero while empty.
module ins_fifo
  #(
    parameter int DEPTH = 4
  )
  (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [31:0]                wr_data,
    input  logic                       pop,
    output logic [31:0]                rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
  );

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == DEPTH_C);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rd_data = empty ? 32'h0 : mem[rd_ptr_reg];

  // Storage write; no reset so the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk) begin
    if (srst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ins_encoder.sv
// Mnemonic-level MIPS instruction encoder: accepts requests over valid/ready,
// packs them into 32-bit words, buffers them and streams them out with a
// sequential byte address. Optional macro ENC_CHECK_EN drops illegal kinds
// and flags them on err; without it they are emitted as NOP.
module ins_encoder
  import ins_encoder_pkg::*;
  #(
    parameter int                 DEPTH     = 4,
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
  )
  (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  ins_t              req_kind,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_shamt,
    input  logic [15:0]       req_imm,
    input  logic [25:0]       req_target,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [31:0]       ins_data,
    output logic [ADDR_W-1:0] ins_addr,
    output logic              err
  );

  logic [31:0]          enc_word;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [ADDR_W-1:0]    addr_reg;

  // Encode straight from the request fields; the FIFO registers the result.
  always_comb begin
    enc_word = encode(req_kind, req_rs, req_rt, req_rd, req_shamt, req_imm, req_target);
  end

  assign req_ready = !fifo_full;
  assign accept    = req_valid && req_ready;
  assign ins_valid = !fifo_empty;
  assign pop       = ins_valid && ins_ready;
  assign ins_addr  = addr_reg;

`ifdef ENC_CHECK_EN
  logic kind_ok;
  logic err_reg;

  assign kind_ok = kind_is_legal(req_kind);
  assign push    = accept && kind_ok;
  assign err     = err_reg;

  // One-cycle error pulse for an accepted-but-dropped illegal kind; a flush discards it.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= accept && !kind_ok;
    end
  end
`else
  assign push = accept;
  assign err  = 1'b0;
`endif

  // Byte address of the head word: advances one word per pop, restarts on flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      addr_reg <= BASE_ADDR;
    end else if (pop) begin
      addr_reg <= addr_reg + ADDR_W'(4);
    end
  end

  ins_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .srst    (rst),
    .flush   (flush),
    .push    (push),
    .wr_data (enc_word),
    .pop     (pop),
    .rd_data (ins_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_ins_encoder.sv
// Scoreboard bench for ins_encoder: expected words are queued at acceptance
// and compared, with a bench-side address model, whenever a word is popped.
module tb_ins_encoder;
  import ins_encoder_pkg::*;

  localparam int          DEPTH  = 4;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              req_valid;
  logic              req_ready;
  ins_t              req_kind;
  logic [4:0]        req_rs, req_rt, req_rd, req_shamt;
  logic [15:0]       req_imm;
  logic [25:0]       req_target;
  logic              ins_valid;
  logic              ins_ready;
  logic [31:0]       ins_data;
  logic [ADDR_W-1:0] ins_addr;
  logic              err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_addr;
  logic [31:0] exp_word;
  logic        exp_push;

  ins_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_shamt(req_shamt),
    .req_imm(req_imm), .req_target(req_target),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_data(ins_data),
    .ins_addr(ins_addr), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Score the current cycle's handshakes, then advance one clock.
  task automatic tick();
    logic [31:0] w;
    if (rst || flush) begin
      exp_q.delete();
      model_addr = BASE;
    end else begin
      if (ins_valid && ins_ready) begin
        if (exp_q.size() == 0) begin
          check("pop_without_expected_word", {31'b0, ins_valid}, 32'h0);
        end else begin
          w = exp_q.pop_front();
          $display("pop  addr=0x%08h data=0x%08h exp=0x%08h", ins_addr, ins_data, w);
          check("data", ins_data, w);
          check("addr", ins_addr, model_addr);
          model_addr = model_addr + 32'd4;
        end
      end
      if (req_valid && req_ready && exp_push) begin
        exp_q.push_back(exp_word);
        $display("push kind=%0d word=0x%08h", req_kind, exp_word);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input ins_t k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic [31:0] w);
    req_valid  = 1'b1;
    req_kind   = k;
    req_rs     = rs;
    req_rt     = rt;
    req_rd     = rd;
    req_shamt  = sh;
    req_imm    = imm;
    req_target = tgt;
    exp_word   = w;
    exp_push   = 1'b1;
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && exp_q.size() > 0; n++) tick();
    check("drain_complete", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int          accepted;
    logic [31:0] head;

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; ins_ready = 1'b0;
    req_kind = INS_NOP; req_rs = '0; req_rt = '0; req_rd = '0; req_shamt = '0;
    req_imm = '0; req_target = '0; exp_word = '0; exp_push = 1'b0;
    model_addr = BASE;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_ins_valid", {31'b0, ins_valid}, 32'd0);
    check("rst_ins_data", ins_data, 32'h0);
    check("rst_ins_addr", ins_addr, BASE);
    check("rst_err", {31'b0, err}, 32'd0);
    rst = 1'b0;

    // Single ADDI, one-cycle latency.
    ins_ready = 1'b1;
    drive(INS_ADDI, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0005, 26'h0, 32'h2022_0005);
    tick();
    req_valid = 1'b0;
    check("addi_valid", {31'b0, ins_valid}, 32'd1);
    check("addi_data", ins_data, 32'h2022_0005);
    check("addi_addr", ins_addr, 32'h0);
    tick();
    check("addi_gone", {31'b0, ins_valid}, 32'd0);

    // Restart addresses, then a back-to-back burst with ignored fields set.
    flush = 1'b1; tick(); flush = 1'b0;
    drive(INS_ADD,  5'd1,  5'd2, 5'd3, 5'd9, 16'hFFFF, 26'h3FF, 32'h0022_1820); tick();
    drive(INS_SLL,  5'd7,  5'd2, 5'd4, 5'd3, 16'h1234, 26'h0,   32'h0002_20C0); tick();
    drive(INS_J,    5'd5,  5'd6, 5'd7, 5'd1, 16'h0,    26'h100, 32'h0800_0100); tick();
    drive(INS_LW,   5'd29, 5'd8, 5'd3, 5'd2, 16'h0004, 26'h55,  32'h8FA8_0004); tick();
    drive(INS_LUI,  5'd9,  5'd5, 5'd1, 5'd1, 16'h1234, 26'h0,   32'h3C05_1234); tick();
    drive(INS_JR,   5'd31, 5'd4, 5'd4, 5'd4, 16'h00FF, 26'h0,   32'h03E0_0008); tick();
    drive(INS_SRAV, 5'd1,  5'd2, 5'd6, 5'd7, 16'h0,    26'h0,   32'h0022_3007); tick();
    req_valid = 1'b0;
    drain();

    // Back-pressure: six offers, four fit, head stays put.
    ins_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      drive(INS_ORI, 5'd0, 5'd1, 5'd0, 5'd0, 16'(i), 26'h0, {6'h0D, 5'd0, 5'd1, 16'(i)});
      if (req_ready) accepted++;
      tick();
    end
    req_valid = 1'b0;
    head = ins_data;
    check("stall_accepted", 32'(accepted), 32'd4);
    check("stall_req_ready_low", {31'b0, req_ready}, 32'd0);
    check("stall_head_word", head, 32'h3401_0000);
    tick();
    check("stall_head_stable", ins_data, 32'h3401_0000);
    ins_ready = 1'b1;
    tick();
    check("ready_after_first_pop", {31'b0, req_ready}, 32'd1);
    drain();

    // Steady streaming at occupancy two.
    ins_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(INS_ADDIU, 5'd3, 5'd4, 5'd0, 5'd0, 16'(50 + i), 26'h0, {6'h09, 5'd3, 5'd4, 16'(50 + i)});
      tick();
    end
    ins_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(INS_ADDIU, 5'd3, 5'd4, 5'd0, 5'd0, 16'(100 + i), 26'h0, {6'h09, 5'd3, 5'd4, 16'(100 + i)});
      tick();
      check("stream_count", 32'(dut.u_fifo.count), 32'd2);
    end
    req_valid = 1'b0;
    drain();

    // Flush with three queued words and a live request.
    ins_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(INS_XORI, 5'd2, 5'd3, 5'd0, 5'd0, 16'(i), 26'h0, {6'h0E, 5'd2, 5'd3, 16'(i)});
      tick();
    end
    drive(INS_BNE, 5'd1, 5'd1, 5'd0, 5'd0, 16'hBEEF, 26'h0, 32'h1421_BEEF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    req_valid = 1'b0;
    check("flush_valid", {31'b0, ins_valid}, 32'd0);
    check("flush_addr", ins_addr, BASE);
    ins_ready = 1'b1;
    repeat (3) tick();
    check("flush_nothing_emitted", {31'b0, ins_valid}, 32'd0);

    // Out-of-range kind.
    drive(ins_t'(5'd31), 5'd1, 5'd2, 5'd3, 5'd4, 16'hABCD, 26'h123, 32'h0);
`ifdef ENC_CHECK_EN
    exp_push = 1'b0;
    tick();
    req_valid = 1'b0;
    check("illegal_err_pulse", {31'b0, err}, 32'd1);
    check("illegal_not_pushed", {31'b0, ins_valid}, 32'd0);
    tick();
    check("illegal_err_clear", {31'b0, err}, 32'd0);
    check("illegal_still_empty", {31'b0, ins_valid}, 32'd0);
`else
    tick();
    req_valid = 1'b0;
    check("illegal_err_low", {31'b0, err}, 32'd0);
    check("illegal_as_nop_valid", {31'b0, ins_valid}, 32'd1);
    check("illegal_as_nop_data", ins_data, 32'h0);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ins_encoder.md
# ins_encoder

Instruction encoder, the write-side counterpart of the MIPS decode path. It accepts instruction requests at the mnemonic level (instruction kind plus operand fields) over a valid/ready handshake. Each request is packed into a 32-bit MIPS word using the shared opcode and function-code constants, buffered in a small FIFO, and streamed out with a sequential word address. It feeds the instruction-memory loader and the self-test program generator.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- ADDR_W, 32: width of the word address output.
- BASE_ADDR, 0: address of the first emitted word after reset or flush.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- flush  in  1  synchronous clear of the FIFO and the address counter.
- req_valid  in  1  a request is present.
- req_ready  out  1  the encoder can accept a request.
- req_kind  in  ins_t  instruction kind.
- req_rs, req_rt, req_rd  in  5 each  register fields.
- req_shamt  in  5  shift amount.
- req_imm  in  16  immediate.
- req_target  in  26  jump target.
- ins_valid  out  1  head word is valid.
- ins_ready  in  1  the consumer takes the head word.
- ins_data  out  32  encoded word.
- ins_addr  out  ADDR_W  byte address of the head word.
- err  out  1  one-cycle pulse when an illegal kind is dropped (ENC_CHECK_EN only).

## Operation
- A request is accepted when req_valid and req_ready are both high. The word is encoded combinationally and written into the FIFO tail on the same edge.
- A word is popped when ins_valid and ins_ready are both high. On each pop the address counter advances by 4, wrapping modulo 2^ADDR_W.
- req_ready = (count < DEPTH). There is no bypass when full: a push and a pop in the same cycle while full cannot occur.
- When 0 < count < DEPTH, a simultaneous push and pop leaves count unchanged and keeps data order.
- Encoding rules:
  - R-type ALU kinds (ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU): {OP_RTYPE, rs, rt, rd, 5'b0, FUNC}.
  - SLL, SRL, SRA: {OP_RTYPE, 5'b0, rt, rd, shamt, FUNC}.
  - SLLV, SRLV, SRAV: {OP_RTYPE, rs, rt, rd, 5'b0, FUNC}.
  - JR: {OP_RTYPE, rs, 15'b0, FUNC_JR}.
  - I-type kinds (ADDI, ADDIU, ORI, XORI, LW, SW, BEQ, BNE, SLTI, SLTIU): {OP, rs, rt, imm}.
  - LUI: {OP_LUI, 5'b0, rt, imm}.
  - J and JAL: {OP, target}.
  - NOP kind: the NOP constant.
- Fields that a kind does not use are ignored and forced to zero in the output word.
- flush has priority over push and pop in its cycle. It sets count to 0 and the address counter to BASE_ADDR, and any request presented in that cycle is discarded.
- rst has the same effect as flush, plus it clears err.

## Timing
- Reset values: req_ready=1, ins_valid=0, ins_data=0, ins_addr=BASE_ADDR, err=0.
- Latency: a request accepted at edge N appears on ins_valid/ins_data after edge N when the FIFO was empty. There is no combinational path from req to ins.
- ins_data and ins_addr are stable while ins_valid=1 and ins_ready=0.
- req_ready depends only on registered state. ins_ready has no combinational path to req_ready.
- Full throughput is one word per cycle in steady state.

## Configuration
- ENC_CHECK_EN defined:
  - A req_kind outside the defined ins_t range is accepted (handshake completes) but is not written to the FIFO.
  - err pulses high for the cycle after acceptance.
- ENC_CHECK_EN undefined:
  - Out-of-range kinds are encoded as NOP and pushed.
  - err is tied to 0.

## Structure
- MIPS_DEF gains the ins_t enum: INS_NOP plus one member per supported mnemonic above.
- MIPS_DEF gains an encode function that maps (ins_t, fields) to a 32-bit word, so that benches can reuse it as a reference model.
- Sub-module ins_fifo: synchronous FIFO of width 32, depth DEPTH, with push, pop, flush, full, empty and count.
- ins_encoder contains the encode logic, the address counter and the check logic.

## Test plan
- Single ADDI rs=1 rt=2 imm=0x0005 with ins_ready=1: ins_data=0x20220005, ins_addr=0x0 one cycle after acceptance.
- Back-to-back ADD rd=3 rs=1 rt=2, then SLL rd=4 rt=2 shamt=3 with req_rs=7 (must be ignored), then J target=0x100, then LW rt=8 rs=29 imm=4:
  - data is 0x00221820, 0x000220C0, 0x08000100, 0x8FA80004;
  - addresses are 0x0, 0x4, 0x8, 0xC.
- ins_ready=0 while 6 requests are offered: exactly 4 are accepted, req_ready goes low, and the head word holds steady. Then set ins_ready=1: all 4 drain in order, and req_ready returns high one cycle after the first pop.
- Simultaneous push and pop at count=2 for 10 cycles: count stays at 2 and the output sequence matches the input sequence.
- flush asserted with 3 words queued and a request present: next cycle ins_valid=0 and ins_addr=BASE_ADDR, and the flushed request never appears.
- With ENC_CHECK_EN, an out-of-range req_kind: err=1 for one cycle and no word is emitted. Without ENC_CHECK_EN, the same request emits 0x00000000.
